prio_arbiter_n: RTL and testbench
=================================

Name: prio_arbiter_n

Overview:
- Parametrised, registered successor to the board-level 4-input priority encoder.
- Arbitrates among N request lines and holds each grant until the request drops or a hold timeout expires.
- Selectable fixed-priority mode (highest index wins) or round-robin mode.
- Retains the enable-in / group-select / enable-out semantics, but all outputs are registered. Sits between debounced button/switch inputs and downstream LED or display logic.

Parameters:
- N, 8, number of request lines (2..32).
- IDX_W, $clog2(N), width of grant index; derived localparam, not overridable.
- MAX_HOLD, 16, max consecutive cycles a grant is held; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- en  in  1  enable-in (Ein); 0 forces all grants and status low.
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  in  N  request lines, active high.
- grant_idx  out  IDX_W  index of current grant holder.
- grant_onehot  out  N  one-hot of holder; all zero when no grant.
- grant_valid  out  1  a grant is active.
- gs  out  1  group select: registered (en && req != 0).
- eout  out  1  enable-out: registered (en && req == 0).

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.

Behaviour:
- Reset values: state = IDLE; grant_idx = 0; grant_onehot = 0; grant_valid = 0; gs = 0; eout = 0; rr pointer ptr = 0; hold counter = 0.
- Reset asserted mid-grant drops all outputs immediately, without waiting for a clock edge.
- gs / eout:
  - Updated every edge from that cycle's en/req; 1-cycle latency.
  - Never both 1. Both 0 when en = 0.
- Winner selection (combinational pick from req & ~mask):
  - Fixed mode: highest set index.
  - RR mode: first set index at or above ptr, wrapping N-1 -> 0.
- State IDLE:
  - If en && req != 0: register winner, grant_valid <= 1, counter <= 1, goto GRANT. Grant is visible 1 cycle after the request.
  - Otherwise stay; outputs remain 0.
- State GRANT:
  - en = 0: release. grant_valid/onehot <= 0, grant_idx <= 0, goto IDLE. Takes priority over all other GRANT events.
  - req[grant_idx] = 0 with other requests pending: hand over on the same edge with no bubble. New winner picked with mask = 0. Stay in GRANT; counter <= 1.
  - req[grant_idx] = 0 with no requests: goto IDLE; outputs cleared.
  - Holder still requesting and counter == MAX_HOLD (MAX_HOLD != 0):
    - Timeout: re-arbitrate with mask = onehot(holder).
    - If the masked set is empty, the holder is re-granted and counter <= 1.
  - Else: hold; counter increments, saturating at MAX_HOLD.
- ptr updates only when a grant is issued in RR mode: ptr <= (winner + 1) mod N. In fixed mode ptr holds its value.
- mode is sampled only when a winner is picked; changing mode mid-grant does not disturb the holder.
- Requests appearing while a grant is held are ignored until release or timeout, even higher-priority ones. No preemption.
- Counter width: $clog2(MAX_HOLD + 1), minimum 1 bit.

Decomposition:
- Package prio_arb_pkg:
  - state enum {IDLE, GRANT};
  - mode constants MODE_FIXED = 1'b0, MODE_RR = 1'b1.
- One sub-module, prio_pick: purely combinational.
  - Inputs: req, mask, base, mode.
  - Outputs: winner index, found flag.
  - Parameter: N.
  - Used once; the top module holds the FSM, ptr, counter and output registers.

Test Plan:
1. Reset/idle: rst_n = 0 mid-grant -> all outputs 0 immediately. Release, en = 1, req = 0 -> next edge eout = 1, gs = 0, grant_valid = 0.
2. Fixed priority: N = 8, mode = 0, en = 1, req = 8'b0010_0110 -> one cycle later grant_idx = 5, onehot = 8'b0010_0000, gs = 1. Drop req[5] -> next edge grant_idx = 2, no bubble.
3. Round robin: mode = 1, req = 8'hFF held; after each release -> grants 0, 1, 2, ..., 7, 0 in order; ptr wraps from 7 to 0.
4. Timeout: MAX_HOLD = 4, mode = 0, req = 8'b1000_0001 held -> idx 7 for 4 cycles, then idx 0 for 4 cycles, alternating. With req = 8'b1000_0000 only -> idx 7 re-granted, grant_valid never drops.
5. Enable drop: grant active, en -> 0 -> next edge grant_valid = 0, gs = 0, eout = 0. en -> 1 with the same req -> re-grant one cycle later.
6. No preemption / mode change: mode = 0, holder idx 1; assert req[6] and flip mode to 1 -> holder stays 1 until req[1] drops, then idx 6 is granted under RR rules from ptr.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the registered N-input priority arbiter.
// Imported by the arbiter top and its combinational winner picker.
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection over req & ~mask: highest index in fixed mode,
// first set index at or above base (wrapping) in round-robin mode.
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] base,
  input  logic             mode,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [N-1:0] cand;
  logic [IDX_W:0] rr_pos;

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = req[gi] & ~mask[gi];
  end

  assign found = |cand;

  // Both loops let the last match win: ascending for fixed, descending distance for RR.
  always_comb begin
    winner = '0;
    rr_pos = '0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) winner = IDX_W'(i);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        rr_pos = (IDX_W + 1)'(base) + (IDX_W + 1)'(k);
        if (rr_pos >= (IDX_W + 1)'(N)) rr_pos = rr_pos - (IDX_W + 1)'(N);
        if (cand[rr_pos]) winner = rr_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered N-input arbiter with fixed/round-robin selection, grant hold with
// optional timeout, and registered group-select / enable-out status.
module prio_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  output logic             grant_valid,
  output logic             gs,
  output logic             eout
);

  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [N-1:0]     onehot_reg, onehot_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             gs_reg, eout_reg;

  logic             any_req, holder_req, cnt_sat, timeout;
  logic [N-1:0]     pick_mask;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             issue, release_g, hold_inc;
  logic [IDX_W-1:0] issue_idx;
  logic [N-1:0]     issue_onehot;

  assign any_req    = |req;
  assign holder_req = req[idx_reg];
  assign cnt_sat    = (cnt_reg == CNT_W'(MAX_HOLD));
  assign timeout    = (MAX_HOLD != 0) && cnt_sat;
  // Only a timeout re-arbitration excludes the still-requesting holder.
  assign pick_mask  = (state_reg == GRANT && holder_req) ? onehot_reg : '0;

  prio_pick #(.N(N)) u_pick (
    .req    (req),
    .mask   (pick_mask),
    .base   (ptr_reg),
    .mode   (mode),
    .winner (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    issue     = 1'b0;
    release_g = 1'b0;
    hold_inc  = 1'b0;
    issue_idx = pick_idx;
    case (state_reg)
      IDLE: issue = en && any_req;
      GRANT: begin
        if (!en) begin
          release_g = 1'b1;
        end else if (!holder_req) begin
          if (any_req) issue = 1'b1;
          else         release_g = 1'b1;
        end else if (timeout) begin
          issue = 1'b1;
          if (!pick_found) issue_idx = idx_reg;
        end else begin
          hold_inc = (MAX_HOLD != 0) && !cnt_sat;
        end
      end
      default: release_g = 1'b1;
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign issue_onehot[gi] = (issue_idx == IDX_W'(gi));
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    onehot_next = onehot_reg;
    valid_next  = valid_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    if (issue) begin
      state_next  = GRANT;
      idx_next    = issue_idx;
      onehot_next = issue_onehot;
      valid_next  = 1'b1;
      cnt_next    = CNT_W'(1);
      if (mode == MODE_RR)
        ptr_next = (issue_idx == IDX_W'(N - 1)) ? '0 : issue_idx + 1'b1;
    end else if (release_g) begin
      state_next  = IDLE;
      idx_next    = '0;
      onehot_next = '0;
      valid_next  = 1'b0;
      cnt_next    = '0;
    end else if (hold_inc) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      ptr_reg    <= '0;
      onehot_reg <= '0;
      valid_reg  <= 1'b0;
      cnt_reg    <= '0;
      gs_reg     <= 1'b0;
      eout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      ptr_reg    <= ptr_next;
      onehot_reg <= onehot_next;
      valid_reg  <= valid_next;
      cnt_reg    <= cnt_next;
      gs_reg     <= en && any_req;
      eout_reg   <= en && !any_req;
    end
  end

  assign grant_idx    = idx_reg;
  assign grant_onehot = onehot_reg;
  assign grant_valid  = valid_reg;
  assign gs           = gs_reg;
  assign eout         = eout_reg;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Self-checking bench for prio_arbiter_n: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_prio_arbiter_n;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;
  localparam int IDX_W    = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [N-1:0]     req;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_onehot;
  logic             grant_valid;
  logic             gs;
  logic             eout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who holds, for how many cycles, and the round-robin start point.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_gs;
  bit m_eout;

  prio_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .req          (req),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .gs           (gs),
    .eout         (eout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int excl, input bit rr, input int base);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--)
        if (r[i] && i != excl) return i;
    end else begin
      for (int k = 0; k < N; k++)
        if (r[(base + k) % N] && ((base + k) % N) != excl) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_gs = 0; m_eout = 0;
  endtask

  task automatic model_grant(input int w);
    m_valid = 1;
    m_idx   = w;
    m_held  = 1;
    if (mode) m_ptr = (w + 1) % N;
  endtask

  task automatic model_release();
    m_valid = 0; m_idx = 0; m_held = 0;
  endtask

  task automatic model_step();
    bit any;
    int w;
    any = (req != '0);
    if (!m_valid) begin
      if (en && any) model_grant(model_pick(req, -1, mode, m_ptr));
    end else if (!en) begin
      model_release();
    end else if (!req[m_idx]) begin
      if (any) model_grant(model_pick(req, -1, mode, m_ptr));
      else     model_release();
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      w = model_pick(req, m_idx, mode, m_ptr);
      model_grant((w < 0) ? m_idx : w);
    end else if (MAX_HOLD != 0) begin
      m_held++;
    end
    m_gs   = en && any;
    m_eout = en && !any;
  endtask

  task automatic compare_all();
    chk("grant_valid", 32'(grant_valid), 32'(m_valid));
    chk("grant_idx", 32'(grant_idx), m_valid ? m_idx : 0);
    chk("grant_onehot", 32'(grant_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
    chk("gs", 32'(gs), 32'(m_gs));
    chk("eout", 32'(eout), 32'(m_eout));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    $display("cyc en=%0b mode=%0b req=%02h -> valid=%0b idx=%0d oh=%02h gs=%0b eout=%0b",
             en, mode, req, grant_valid, grant_idx, grant_onehot, gs, eout);
    compare_all();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear at once.
  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_onehot", 32'(grant_onehot), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_gs_eout", 32'({gs, eout}), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Reset mid-grant, then idle with enable high.
    en = 1'b1; req = 8'h10;
    step();
    chk("pre_rst_valid", 32'(grant_valid), 32'd1);
    async_reset_pulse();
    req = '0;
    step();
    chk("idle_eout", 32'(eout), 32'd1);
    chk("idle_gs", 32'(gs), 32'd0);

    // Fixed priority with no-bubble handover.
    mode = 1'b0; req = 8'b0010_0110;
    step();
    chk("fix_idx", 32'(grant_idx), 32'd5);
    chk("fix_onehot", 32'(grant_onehot), 32'h20);
    req = 8'b0000_0110;
    step();
    chk("fix_handover", 32'(grant_idx), 32'd2);
    chk("fix_nobubble", 32'(grant_valid), 32'd1);

    // Round robin over all-ones, releasing the holder each cycle.
    req = '0;
    step();
    mode = 1'b1; req = 8'hFF;
    step();
    chk("rr_first", 32'(grant_idx), 32'd0);
    for (int k = 1; k <= N; k++) begin
      req = 8'hFF & ~(8'd1 << grant_idx);
      step();
      chk("rr_seq", 32'(grant_idx), 32'(k % N));
      req = 8'hFF;
    end

    // Timeout alternation, then lone requester re-granted.
    mode = 1'b0; req = '0;
    step();
    req = 8'b1000_0001;
    for (int s = 1; s <= 16; s++) begin
      step();
      chk("to_alt", 32'(grant_idx), (((s - 1) / MAX_HOLD) % 2 == 0) ? 32'd7 : 32'd0);
    end
    req = 8'b1000_0000;
    for (int s = 0; s < 10; s++) begin
      step();
      chk("to_regrant_valid", 32'(grant_valid), 32'd1);
      chk("to_regrant_idx", 32'(grant_idx), 32'd7);
    end

    // Enable drop and re-grant.
    en = 1'b0;
    step();
    chk("en_drop_valid", 32'(grant_valid), 32'd0);
    chk("en_drop_gs_eout", 32'({gs, eout}), 32'd0);
    en = 1'b1;
    step();
    chk("en_regrant", 32'({grant_valid, 3'(grant_idx)}), 32'h0F);

    // No preemption, mode flip mid-grant, RR pick from pointer afterwards.
    req = '0;
    step();
    mode = 1'b0; req = 8'b0000_0010;
    step();
    req = 8'b0100_0010; mode = 1'b1;
    for (int s = 0; s < 2; s++) begin
      step();
      chk("nopreempt", 32'(grant_idx), 32'd1);
    end
    req = 8'b0100_0000;
    step();
    chk("mode_flip_winner", 32'(grant_idx), 32'd6);

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = '0;
          1:       req = 8'(1 << $urandom_range(0, N - 1));
          default: req = 8'($urandom);
        endcase
      end
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
